gcd_lcm_calc: RTL and testbench
===============================

Name: gcd_lcm_calc

Overview:
Downstream consumer of the gcd core. It takes the same operand pair fed to the gcd core plus the core's settled gcd_out, and computes LCM = (xin / gcd_in) * yin with a sequential restoring divider followed by a shift-add multiplier. The parent controller asserts start once gcd_out is stable. The block reports the result with a one-cycle done pulse and an err flag when gcd_in is inconsistent with the operands.

Parameters:
WIDTH, 8, operand width of xin, yin and gcd_in; lcm_out is 2*WIDTH bits wide.

Ports:
clk      input   1          system clock; all state updates on rising edge
clr      input   1          asynchronous, active-high reset
start    input   1          request; sampled only in IDLE
xin      input   WIDTH      operand x (unsigned)
yin      input   WIDTH      operand y (unsigned)
gcd_in   input   WIDTH      gcd of xin, yin, taken from the gcd core's gcd_out
busy     output  1          high in every state except IDLE
done     output  1          one-cycle pulse when the result is valid
err      output  1          result invalid; valid with done, held afterwards
lcm_out  output  2*WIDTH    LCM result; held until the next accepted start

Behaviour:
- Reset: clr high forces state IDLE immediately (asynchronous). busy=0, done=0, err=0, lcm_out=0. All internal registers are cleared.
- Reset mid-operation aborts the computation. No done pulse is produced, and outputs return to their reset values.
- FSM states: IDLE, DIV, MUL, DONE.
- IDLE, with start=1 at a rising edge:
  - Latch xin, yin and gcd_in.
  - If xin==0 or yin==0: next state is DONE, with lcm=0 and err=0.
  - Else if gcd_in==0: next state is DONE, with lcm=0 and err=1.
  - Otherwise: next state is DIV with the bit counter set to 0.
- DIV: one restoring-division step per cycle for WIDTH cycles, MSB first. Remainder register is WIDTH+1 bits; quotient register is WIDTH bits.
  - After the WIDTH-th step, if the remainder is nonzero: next state is DONE, with lcm=0 and err=1.
  - Otherwise: next state is MUL.
- MUL: quotient * latched yin by shift-add over WIDTH cycles, using a 2*WIDTH-bit accumulator.
  - The product cannot overflow because quotient ≤ 2^WIDTH-1 and yin ≤ 2^WIDTH-1.
  - After WIDTH cycles: next state is DONE.
- DONE: lasts exactly 1 cycle, with done=1.
  - lcm_out and err are registered on entry to DONE and hold until the next accepted start.
  - Next state is IDLE.
- Latency, counted in rising edges after the edge that samples start, to the edge that raises done:
  - Normal path: 2*WIDTH+1 (17 for WIDTH=8).
  - Zero-operand or gcd_in==0: 1.
  - Nonzero remainder: WIDTH+1.
- start while busy=1 (DIV, MUL or DONE) is ignored and not queued. Changes on xin, yin or gcd_in after acceptance have no effect.
- start held high continuously: a new operation is accepted on the first IDLE cycle after DONE.
- All arithmetic is unsigned. There is no rounding and no saturation.

Test Plan:
- Reset, then start with xin=3, yin=6, gcd_in=3 -> done exactly 17 cycles after start is sampled; lcm_out=6, err=0; busy high for 17 cycles.
- xin=49, yin=35, gcd_in=7 -> lcm_out=245, err=0. Next, xin=255, yin=254, gcd_in=1 -> lcm_out=64770 (max-range product, no overflow).
- xin=0, yin=5, gcd_in=5 -> done after 1 cycle, lcm_out=0, err=0. xin=10, yin=4, gcd_in=0 -> done after 1 cycle, err=1, lcm_out=0.
- Inconsistent gcd: xin=10, yin=4, gcd_in=3 -> done after 9 cycles, err=1, lcm_out=0. err stays high until the next accepted start.
- Pulse start again with different operands while busy (for example at cycle 5 of xin=3, yin=6, gcd_in=3) -> ignored; the first result (6) is unchanged. Assert clr at cycle 10 of a second run -> busy, done and lcm_out go to 0 immediately, and no done pulse follows.

Source files
------------

// File: rtl/gcd_lcm_calc.sv
// gcd_lcm_calc: computes LCM = (xin / gcd_in) * yin from an operand pair and
// the gcd reported by the upstream gcd core. A restoring divider runs for
// WIDTH cycles, then a shift-add multiplier runs for WIDTH cycles. The result
// is reported with a one-cycle done pulse. err flags a gcd_in that cannot be
// the gcd of the operands: either it is zero or it does not divide xin.
//
// Handshake: start is a request level sampled only while busy=0 (IDLE). The
// edge that samples it accepts the operands. A start seen while busy=1 is
// dropped, not queued. done is high for exactly one cycle, and lcm_out/err are
// valid in that cycle. They then hold until the next accepted start.
module gcd_lcm_calc #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [WIDTH-1:0]     xin,
  input  logic [WIDTH-1:0]     yin,
  input  logic [WIDTH-1:0]     gcd_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2*WIDTH-1:0]   lcm_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;

  state_t               state;
  state_t               state_nxt;

  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     dvd;      // dividend, shifted left one bit per DIV step
  logic [WIDTH-1:0]     gcd_r;    // latched divisor
  logic [WIDTH:0]       rem;      // partial remainder
  logic [WIDTH-1:0]     quo;      // quotient; shifted right during MUL
  logic [2*WIDTH-1:0]   mcand;    // latched yin, shifted left during MUL
  logic [2*WIDTH-1:0]   acc;      // product accumulator

  logic [WIDTH:0]       trial;
  logic [WIDTH:0]       rem_step;
  logic                 q_bit;
  logic [2*WIDTH-1:0]   acc_step;
  logic                 last_step;
  logic                 zero_op;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // One restoring-division step, one shift-add step, and the decode of the step counter
  always_comb begin
    trial     = (rem << 1) | {{WIDTH{1'b0}}, dvd[WIDTH-1]};
    rem_step  = trial;
    q_bit     = 1'b0;
    if (trial >= {1'b0, gcd_r}) begin
      rem_step = trial - {1'b0, gcd_r};
      q_bit    = 1'b1;
    end
    acc_step  = quo[0] ? (acc + mcand) : acc;
    last_step = (cnt == CW'(WIDTH - 1));
    zero_op   = (xin == '0) || (yin == '0);
  end

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (zero_op || (gcd_in == '0)) state_nxt = DONE;
          else                           state_nxt = DIV;
        end
      end
      DIV: begin
        if (last_step) state_nxt = (rem_step != '0) ? DONE : MUL;
      end
      MUL: begin
        if (last_step) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, divide and multiply steps, result registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt     <= '0;
      dvd     <= '0;
      gcd_r   <= '0;
      rem     <= '0;
      quo     <= '0;
      mcand   <= '0;
      acc     <= '0;
      lcm_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            dvd     <= xin;
            gcd_r   <= gcd_in;
            rem     <= '0;
            quo     <= '0;
            mcand   <= {{WIDTH{1'b0}}, yin};
            acc     <= '0;
            lcm_out <= '0;
            // Zero operands give lcm 0 and are not an error; a zero gcd with
            // nonzero operands is.
            err     <= !zero_op && (gcd_in == '0);
          end
        end
        DIV: begin
          rem <= rem_step;
          quo <= {quo[WIDTH-2:0], q_bit};
          dvd <= dvd << 1;
          cnt <= last_step ? '0 : cnt + CW'(1);
          if (last_step && (rem_step != '0)) begin
            lcm_out <= '0;
            err     <= 1'b1;
          end
        end
        MUL: begin
          acc   <= acc_step;
          mcand <= mcand << 1;
          quo   <= quo >> 1;
          cnt   <= last_step ? '0 : cnt + CW'(1);
          if (last_step) begin
            lcm_out <= acc_step;
            err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_lcm_calc.sv
// Testbench for gcd_lcm_calc: directed scenarios plus randomized operands
// checked against an arithmetic reference model.
module tb_gcd_lcm_calc;

  localparam int W = 8;

  logic           clk;
  logic           clr;
  logic           start;
  logic [W-1:0]   xin;
  logic [W-1:0]   yin;
  logic [W-1:0]   gcd_in;
  logic           busy;
  logic           done;
  logic           err;
  logic [2*W-1:0] lcm_out;

  int checks;
  int errors;

  logic [2*W-1:0] exp_q[$];
  logic           exp_err_q[$];
  int             exp_lat_q[$];

  gcd_lcm_calc #(.WIDTH(W)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .xin     (xin),
    .yin     (yin),
    .gcd_in  (gcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .lcm_out (lcm_out)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected lcm, err and latency from plain arithmetic
  function automatic void model(input int x, input int y, input int g);
    if (x == 0 || y == 0) begin
      exp_q.push_back('0); exp_err_q.push_back(1'b0); exp_lat_q.push_back(1);
    end else if (g == 0) begin
      exp_q.push_back('0); exp_err_q.push_back(1'b1); exp_lat_q.push_back(1);
    end else if (x % g != 0) begin
      exp_q.push_back('0); exp_err_q.push_back(1'b1); exp_lat_q.push_back(W + 1);
    end else begin
      exp_q.push_back((2*W)'((x / g) * y));
      exp_err_q.push_back(1'b0);
      exp_lat_q.push_back(2 * W + 1);
    end
  endfunction

  function automatic int true_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b; a = b; b = t;
    end
    return a;
  endfunction

  // Driver: present operands with start for one sampling edge
  task automatic launch(input int x, input int y, input int g);
    @(negedge clk);
    xin = W'(x); yin = W'(y); gcd_in = W'(g); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the operands after acceptance; they must have no effect
    xin = W'($urandom); yin = W'($urandom); gcd_in = W'($urandom);
  endtask

  // Wait for done, counting sampling edges (first one included) and busy cycles
  task automatic wait_done(output int cycles, output int busy_cnt, output bit timeout);
    cycles = 1; busy_cnt = 0; timeout = 1'b0;
    while (1) begin
      if (busy) busy_cnt++;
      if (done) break;
      if (cycles >= 100) begin timeout = 1'b1; break; end
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  // Launch one operation, then compare against the model's queued expectations
  task automatic run_checked(input string name, input int x, input int y, input int g);
    int cyc, bc; bit to;
    logic [2*W-1:0] e_lcm; logic e_err; int e_lat;
    model(x, y, g);
    launch(x, y, g);
    wait_done(cyc, bc, to);
    e_lcm = exp_q.pop_front(); e_err = exp_err_q.pop_front(); e_lat = exp_lat_q.pop_front();
    checks++;
    if (to) begin
      errors++; $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
    end else begin
      checks++;
      if (cyc !== e_lat) begin
        errors++; $display("FAIL %s latency: got %0d expected %0d (x=%0d y=%0d g=%0d)", name, cyc, e_lat, x, y, g);
      end
      checks++;
      if (lcm_out !== e_lcm) begin
        errors++; $display("FAIL %s lcm_out: got %0d expected %0d (x=%0d y=%0d g=%0d)", name, lcm_out, e_lcm, x, y, g);
      end
      checks++;
      if (err !== e_err) begin
        errors++; $display("FAIL %s err: got %0b expected %0b (x=%0d y=%0d g=%0d)", name, err, e_err, x, y, g);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; xin = '0; yin = '0; gcd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, lcm_out} !== '0) begin
      errors++; $display("FAIL reset: busy=%0b done=%0b err=%0b lcm=%0d expected all 0", busy, done, err, lcm_out);
    end
    @(negedge clk); clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc, bc; bit to;
    launch(3, 6, 3);
    wait_done(cyc, bc, to);
    checks++;
    if (cyc !== 17) begin errors++; $display("FAIL basic latency: got %0d expected 17", cyc); end
    checks++;
    if (bc !== 17) begin errors++; $display("FAIL basic busy cycles: got %0d expected 17", bc); end
    checks++;
    if (lcm_out !== 16'd6 || err !== 1'b0) begin
      errors++; $display("FAIL basic result: lcm=%0d err=%0b expected 6/0", lcm_out, err);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || lcm_out !== 16'd6) begin
      errors++; $display("FAIL basic after: done=%0b busy=%0b lcm=%0d expected 0/0/6", done, busy, lcm_out);
    end
  endtask

  task automatic test_directed();
    run_checked("d49_35", 49, 35, 7);
    checks++;
    if (lcm_out !== 16'd245) begin errors++; $display("FAIL d49_35 hold: got %0d expected 245", lcm_out); end
    run_checked("dmax", 255, 254, 1);
    checks++;
    if (lcm_out !== 16'd64770) begin errors++; $display("FAIL dmax hold: got %0d expected 64770", lcm_out); end
    run_checked("dzero_x", 0, 5, 5);
    run_checked("dzero_g", 10, 4, 0);
    run_checked("dbad_g", 10, 4, 3);
    // err and lcm must hold while idle
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1 || lcm_out !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL err hold: err=%0b lcm=%0d busy=%0b expected 1/0/0", err, lcm_out, busy);
    end
    run_checked("dclear_err", 4, 6, 2);
  endtask

  task automatic test_busy_start();
    int cyc; bit seen;
    launch(3, 6, 3);
    cyc = 1; seen = 1'b0;
    while (cyc < 60) begin
      if (done) begin seen = 1'b1; break; end
      if (cyc == 5) begin
        @(negedge clk);
        start = 1'b1; xin = 8'd100; yin = 8'd50; gcd_in = 8'd50;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    checks++;
    if (!seen || cyc !== 17 || lcm_out !== 16'd6 || err !== 1'b0) begin
      errors++; $display("FAIL busy_start: seen=%0b cyc=%0d lcm=%0d err=%0b expected 1/17/6/0", seen, cyc, lcm_out, err);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || lcm_out !== 16'd6) begin
      errors++; $display("FAIL busy_start queued: busy=%0b lcm=%0d expected 0/6", busy, lcm_out);
    end
  endtask

  task automatic test_clr_mid();
    int n; bit bad;
    launch(3, 6, 3);
    repeat (9) @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || lcm_out !== '0 || err !== 1'b0) begin
      errors++; $display("FAIL clr_mid: busy=%0b done=%0b lcm=%0d err=%0b expected all 0", busy, done, lcm_out, err);
    end
    @(negedge clk); clr = 1'b0;
    bad = 1'b0;
    for (n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done || busy) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL clr_mid aborted: activity after clr, got 1 expected 0"); end
    run_checked("after_clr", 12, 18, 6);
  endtask

  task automatic test_held_start();
    int cyc, bc, gap, idle_n; bit to;
    @(negedge clk);
    xin = 8'd3; yin = 8'd6; gcd_in = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    xin = 8'd49; yin = 8'd35; gcd_in = 8'd7;
    wait_done(cyc, bc, to);
    checks++;
    if (to || cyc !== 17 || lcm_out !== 16'd6) begin
      errors++; $display("FAIL held first: cyc=%0d lcm=%0d expected 17/6", cyc, lcm_out);
    end
    gap = 0; idle_n = 0;
    do begin
      @(posedge clk); #1;
      gap++;
      if (!busy) idle_n++;
    end while (!done && gap < 60);
    start = 1'b0;
    checks++;
    if (gap !== 2 * W + 2 || idle_n !== 1) begin
      errors++; $display("FAIL held gap: gap=%0d idle=%0d expected %0d/1", gap, idle_n, 2 * W + 2);
    end
    checks++;
    if (lcm_out !== 16'd245 || err !== 1'b0) begin
      errors++; $display("FAIL held second: lcm=%0d err=%0b expected 245/0", lcm_out, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int x, y, g, mode;
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 4);
      x = $urandom_range(1, 255);
      y = $urandom_range(1, 255);
      case (mode)
        0, 1: g = true_gcd(x, y);
        2:    g = $urandom_range(1, 255);
        3:    g = 0;
        default: begin
          if ($urandom_range(0, 1) == 0) x = 0; else y = 0;
          g = $urandom_range(0, 255);
        end
      endcase
      run_checked("random", x, y, g);
    end
  endtask

  // Sequencer and final report
  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_basic();
    test_directed();
    test_busy_start();
    test_clr_mid();
    test_held_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
